// File: rtl/fetch_ifid_stage_pkg.sv
// Shared definitions for the fetch / IF-ID stage: jump-select encodings,
// bubble word and default reset PC.
package fetch_ifid_stage_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        JMUX_SEQ = 2'b00,
        JMUX_J   = 2'b01,
        JMUX_JR  = 2'b10,
        JMUX_RSV = 2'b11
    } jmux_e;

    localparam logic [XLEN-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Build the j/jal target from the upper PC+4 bits and the 26-bit index.
    function automatic logic [XLEN-1:0] jump_target(input logic [3:0]  pc_hi,
                                                     input logic [25:0] index);
        return {pc_hi, index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ifid_stage_next_pc_sel.sv
// Next-PC priority mux: stall > redirect (branch > j/jal > jr) > sequential.
// Ports:
//   pc             current fetch PC
//   stall          hazard-unit hold
//   valid_id       IF/ID holds a real instruction (gates redirects)
//   pc_src         branch taken
//   branch_target  branch destination
//   jmux           jump select (seq / j / jr / reserved)
//   jr_target      rs value for jr
//   jump_index     IF/ID instruction [25:0]
//   pc_hi          IF/ID PC+4 [31:28]
//   next_pc        PC to load at the next edge (word aligned)
//   redirect       a redirect is being taken this cycle
module fetch_ifid_stage_next_pc_sel
    import fetch_ifid_stage_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            valid_id,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target,
    input  logic [1:0]      jmux,
    input  logic [XLEN-1:0] jr_target,
    input  logic [25:0]     jump_index,
    input  logic [3:0]      pc_hi,
    output logic [XLEN-1:0] next_pc,
    output logic            redirect
);

    logic [XLEN-1:0] raw_pc;

    always_comb begin
        raw_pc   = pc + XLEN'(4);
        redirect = 1'b0;
        if (stall) begin
            raw_pc = pc;
        end else if (valid_id) begin
            if (pc_src) begin
                raw_pc   = branch_target;
                redirect = 1'b1;
            end else if (jmux == JMUX_J) begin
                raw_pc   = jump_target(pc_hi, jump_index);
                redirect = 1'b1;
            end else if (jmux == JMUX_JR) begin
                raw_pc   = jr_target;
                redirect = 1'b1;
            end
        end
    end

    // Word alignment; the hold and sequential paths are already aligned.
    assign next_pc = raw_pc & ~XLEN'(3);

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch + IF/ID pipeline register with ID-retire counter.
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   IMemAddr        fetch PC to instruction memory (combinational from PC)
//   IMemData        instruction word at IMemAddr, same cycle
//   Stall           hold PC and IF/ID
//   Flush           bubble IF/ID
//   PCSrc, BranchTarget, Jmux, JrTarget   redirects resolved in ID
//   Instruction_ID, PCPlus4_ID, Valid_ID  IF/ID register contents
//   InstrCount      instructions leaving ID
module fetch_ifid_stage
    import fetch_ifid_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemData,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [1:0]  Jmux,
    input  logic [31:0] JrTarget,
    output logic [31:0] Instruction_ID,
    output logic [31:0] PCPlus4_ID,
    output logic        Valid_ID,
    output logic [31:0] InstrCount
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            redirect;

    fetch_ifid_stage_next_pc_sel u_next_pc_sel (
        .pc            (pc),
        .stall         (Stall),
        .valid_id      (Valid_ID),
        .pc_src        (PCSrc),
        .branch_target (BranchTarget),
        .jmux          (Jmux),
        .jr_target     (JrTarget),
        .jump_index    (Instruction_ID[25:0]),
        .pc_hi         (PCPlus4_ID[31:28]),
        .next_pc       (next_pc),
        .redirect      (redirect)
    );

    assign IMemAddr = pc;

    // PC, IF/ID and retire counter; flush overrides stall on IF/ID only.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc             <= RESET_PC;
            Instruction_ID <= NOP_WORD;
            PCPlus4_ID     <= '0;
            Valid_ID       <= 1'b0;
            InstrCount     <= '0;
        end else begin
            pc <= next_pc;
            if (Flush || (!Stall && redirect)) begin
                Instruction_ID <= NOP_WORD;
                Valid_ID       <= 1'b0;
            end else if (!Stall) begin
                Instruction_ID <= IMemData;
                PCPlus4_ID     <= pc + XLEN'(4);
                Valid_ID       <= 1'b1;
            end
            if (Valid_ID && !Stall && !Flush) begin
                InstrCount <= InstrCount + XLEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed bench for fetch_ifid_stage with a small instruction-memory model.
module tb_fetch_ifid_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] IMemAddr;
    logic [31:0] IMemData;
    logic        Stall;
    logic        Flush;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic [1:0]  Jmux;
    logic [31:0] JrTarget;
    logic [31:0] Instruction_ID;
    logic [31:0] PCPlus4_ID;
    logic        Valid_ID;
    logic [31:0] InstrCount;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] I_ADD = 32'h0043_0820;
    localparam logic [31:0] I_SUB = 32'h0043_0822;
    localparam logic [31:0] I_LW  = 32'h8C41_0000;
    localparam logic [31:0] I_OR  = 32'h0043_0825;
    localparam logic [31:0] I_J   = 32'h0810_0000;

    fetch_ifid_stage dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .IMemAddr       (IMemAddr),
        .IMemData       (IMemData),
        .Stall          (Stall),
        .Flush          (Flush),
        .PCSrc          (PCSrc),
        .BranchTarget   (BranchTarget),
        .Jmux           (Jmux),
        .JrTarget       (JrTarget),
        .Instruction_ID (Instruction_ID),
        .PCPlus4_ID     (PCPlus4_ID),
        .Valid_ID       (Valid_ID),
        .InstrCount     (InstrCount)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return I_ADD;
            32'h4:   return I_SUB;
            32'h8:   return I_LW;
            32'hC:   return I_OR;
            32'h10:  return I_J;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    assign IMemData = mem_word(IMemAddr);

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] p4, input logic v, input logic [31:0] cnt);
        chk({tag, ".pc"},    IMemAddr,           pc);
        chk({tag, ".instr"}, Instruction_ID,     ins);
        chk({tag, ".pc4"},   PCPlus4_ID,         p4);
        chk({tag, ".valid"}, 32'(Valid_ID),      32'(v));
        chk({tag, ".count"}, InstrCount,         cnt);
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; PCSrc = 1'b0;
        BranchTarget = '0; Jmux = 2'b00; JrTarget = '0;
        step(); step();
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        Reset = 1'b0;
        step(); chk_all("seq1", 32'h4, I_ADD, 32'h4, 1'b1, 32'd0);
        step(); chk_all("seq2", 32'h8, I_SUB, 32'h8, 1'b1, 32'd1);
        step(); chk_all("lw",   32'hC, I_LW,  32'hC, 1'b1, 32'd2);

        Stall = 1'b1;
        step(); chk_all("stall", 32'hC, I_LW, 32'hC, 1'b1, 32'd2);
        Stall = 1'b0;
        step(); chk_all("resume", 32'h10, I_OR, 32'h10, 1'b1, 32'd3);
        step(); chk_all("j_in_id", 32'h14, I_J, 32'h14, 1'b1, 32'd4);

        Jmux = 2'b01;
        step(); chk_all("jump", 32'h0040_0000, 32'h0, 32'h14, 1'b0, 32'd5);
        Jmux = 2'b00;

        // Redirect while Valid_ID=0 is ignored.
        PCSrc = 1'b1; BranchTarget = 32'h24;
        step(); chk_all("inv_redir", 32'h0040_0004, 32'hA5E5_0000, 32'h0040_0004, 1'b1, 32'd5);

        // Branch beats jr in the same cycle.
        Jmux = 2'b10; JrTarget = 32'h80;
        step(); chk_all("br_wins", 32'h24, 32'h0, 32'h0040_0004, 1'b0, 32'd6);
        PCSrc = 1'b0; Jmux = 2'b00;

        step(); chk_all("seq3", 32'h28, 32'hA5A5_0024, 32'h28, 1'b1, 32'd6);

        // Redirect under stall is ignored.
        Stall = 1'b1; PCSrc = 1'b1; BranchTarget = 32'h100;
        step(); chk_all("stall_redir", 32'h28, 32'hA5A5_0024, 32'h28, 1'b1, 32'd6);
        Stall = 1'b0; PCSrc = 1'b0;

        Flush = 1'b1;
        step(); chk_all("flush", 32'h2C, 32'h0, 32'h28, 1'b0, 32'd6);
        Flush = 1'b0;
        step(); chk_all("seq4", 32'h30, 32'hA5A5_002C, 32'h30, 1'b1, 32'd6);

        Flush = 1'b1; Stall = 1'b1;
        step(); chk_all("flush_stall", 32'h30, 32'h0, 32'h30, 1'b0, 32'd6);
        Flush = 1'b0; Stall = 1'b0;
        step(); chk_all("seq5", 32'h34, 32'hA5A5_0030, 32'h34, 1'b1, 32'd6);

        // Unaligned branch target is word aligned on load.
        PCSrc = 1'b1; BranchTarget = 32'h43;
        step(); chk_all("align", 32'h40, 32'h0, 32'h34, 1'b0, 32'd7);
        PCSrc = 1'b0;
        step(); chk_all("seq6", 32'h44, 32'hA5A5_0040, 32'h44, 1'b1, 32'd7);

        Jmux = 2'b10; JrTarget = 32'hFFFF_FFFF;
        step(); chk_all("jr", 32'hFFFF_FFFC, 32'h0, 32'h44, 1'b0, 32'd8);
        Jmux = 2'b00;
        step(); chk_all("wrap", 32'h0, 32'h5A5A_FFFC, 32'h0, 1'b1, 32'd8);

        // Reserved Jmux encoding is sequential.
        Jmux = 2'b11; JrTarget = 32'h200;
        step(); chk_all("jmux11", 32'h4, I_ADD, 32'h4, 1'b1, 32'd9);
        Jmux = 2'b00;

        Stall = 1'b1;
        step(); chk_all("stall2", 32'h4, I_ADD, 32'h4, 1'b1, 32'd9);
        Reset = 1'b1; Jmux = 2'b01;
        step(); chk_all("reset_stall", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
